// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage initiator and the data-memory responder.
interface dmem_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_sel;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (output ce, we, addr, wdata, byte_sel, input busy, done, rdata, err);
  modport slave  (input ce, we, addr, wdata, byte_sel, output busy, done, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with byte-lane writes; one request at a time,
// busy for LATENCY cycles, then a one-cycle done pulse with registered read data.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  ram
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_we;
  logic                  unused_addr_lsb;

  logic [31:0] mem [DEPTH];

  // Low address bits only select a lane, which the initiator encodes in byte_sel.
  assign unused_addr_lsb = ^ram.addr[1:0];

  assign mem_we = !rst && (state_q == S_BUSY) && (cnt_q == 4'd0) && we_q && !oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ram.ce) begin
          idx_d   = ram.addr[ADDR_WIDTH+1:2];
          oor_d   = |ram.addr[31:ADDR_WIDTH+2];
          we_d    = ram.we;
          wdata_d = ram.wdata;
          sel_d   = ram.byte_sel;
          cnt_d   = 4'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end else begin
          // Access happens on the edge that leaves BUSY.
          if (!we_q) rdata_d = oor_q ? 32'd0 : mem[idx_q];
          done_d  = 1'b1;
          err_d   = oor_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) mem[idx_q][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

  assign ram.busy  = busy_q;
  assign ram.done  = done_q;
  assign ram.err   = err_q;
  assign ram.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2/1/4), vector table plus
// scoreboard on the LATENCY=2 instance, protocol monitors on all three.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ce;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [2:0]  busy_v, done_v, err_v;
  logic [31:0] rdata_v [3];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        held = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  dmem_if bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    assign bus[g].ce       = ce[g];
    assign bus[g].we       = we;
    assign bus[g].addr     = addr;
    assign bus[g].wdata    = wdata;
    assign bus[g].byte_sel = sel;
    assign busy_v[g]       = bus[g].busy;
    assign done_v[g]       = bus[g].done;
    assign err_v[g]        = bus[g].err;
    assign rdata_v[g]      = bus[g].rdata;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .ram (bus[g].slave)
    );

    int   bw   = 0;
    logic ab   = 1'b0;
    int   last = -1;
    always @(negedge clk) begin
      if (busy_v[g]) begin
        bw++;
        if (rst) ab = 1'b1;
      end else if (bw > 0) begin
        if (!ab) check($sformatf("busy_width[L=%0d]", L), bw, L);
        bw = 0;
        ab = 1'b0;
      end
      if (busy_v[g] && done_v[g]) check("busy_done_overlap", done_v[g], 1'b0);
      if (!done_v[g] && err_v[g]) check("err_outside_done", err_v[g], 1'b0);
      if (done_v[g]) begin
        if (held && last >= 0) check($sformatf("done_spacing[L=%0d]", L), cyc - last, L + 2);
        last = held ? cyc : -1;
      end
    end
  end

  // Scoreboard on the LATENCY=2 instance
  always @(negedge clk) begin
    if (done_v[0]) begin
      if (sb.size() == 0) check("unexpected_done", done_v[0], 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", rdata_v[0], e.rdata);
        check("err", err_v[0], e.err);
      end
    end
  end

  // Called just after a rising edge with instance 0 idle.
  task automatic req(input vec_t v);
    int n;
    sb.push_back('{rdata: v.exp_rd, err: v.exp_err});
    ce[0] = 1'b1; we = v.we; addr = v.addr; wdata = v.data; sel = v.sel;
    @(posedge clk); #1;
    ce[0] = 1'b0; we = 1'b1; addr = 32'h0; wdata = $urandom; sel = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_v[0] && n <= 20);
    check("req_latency", n, 3);
    @(posedge clk); #1;
  endtask

  task automatic held_run(input int g, input int ndone, input logic [31:0] exp_rd);
    int k, t;
    held = 1'b1;
    if (g == 0) for (int i = 0; i < ndone; i++) sb.push_back('{rdata: exp_rd, err: 1'b0});
    ce[g] = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'h0;
    k = 0; t = 0;
    while (k < ndone && t < 200) begin
      @(negedge clk);
      t++;
      if (done_v[g]) k++;
    end
    ce[g] = 1'b0;
    check("held_done_count", k, ndone);
    repeat (8) @(posedge clk);
    #1 held = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h11,       32'hAAAAAAAA, 4'b0010, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'b0001, 32'hDEADAAEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h12,       32'h12341234, 4'b1100, 32'hDEADAAEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'h1234AAEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'b0000, 32'h1234AAEF, 1'b0};
    vecs[7]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 32'h1234AAEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h1234AAEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h1000,     32'h0,        4'b1111, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h1000,     32'h11111111, 4'b1111, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 32'h20,       32'h5A5A5A5A, 4'b1111, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 32'h80000010, 32'h0,        4'b0000, 32'h0,        1'b1};

    rst = 1'b1; ce = '0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("reset_busy", busy_v[g], 1'b0);
      check("reset_done", done_v[g], 1'b0);
      check("reset_err", err_v[g], 1'b0);
      check("reset_rdata", rdata_v[g], 32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) req(vecs[i]);

    // Reset during the first BUSY cycle of a write: no done, write dropped.
    ce[0] = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; sel = 4'hF;
    @(posedge clk); #1;
    ce[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    check("abort_rdata", rdata_v[0], 32'h0);
    repeat (3) @(posedge clk); #1;
    req('{1'b0, 32'h20, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0});

    // Reset and request on the same edge: request is dropped.
    ce[0] = 1'b1; rst = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0; sel = 4'hF;
    @(posedge clk); #1 ce[0] = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_ce_busy", busy_v[0], 1'b0);
    repeat (4) @(posedge clk); #1;
    req('{1'b0, 32'h20, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0});

    held_run(0, 3, 32'h1234AAEF);
    held_run(1, 3, 32'h0);
    held_run(2, 3, 32'h0);

    repeat (4) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's memory-stage RAM interface. It accepts a single request (chip-enable, write-enable, address, data, byte lanes), holds busy for a configurable wait time and then pulses done.
- Read data is returned as a full 32-bit word. The initiator extracts byte and halfword lanes.
- Backed by an internal word-organised array with per-byte write enables. It sits between the MEM stage and the rest of the memory subsystem.

Parameters:
- ADDR_WIDTH, 10, word-address bits (array depth = 2^ADDR_WIDTH words = 4 KiB by default).
- LATENCY, 2, BUSY cycles per access. Legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- ram_ce_i  input  1  request valid
- ram_we_i  input  1  1 = write, 0 = read
- ram_addr_i  input  32  byte address; bits [1:0] ignored for indexing
- ram_data_i  input  32  write data, already lane-replicated by initiator
- ram_byte_sel_i  input  4  byte-lane write enables; bit n = bits [8n+7:8n]
- ram_busy_o  output  1  access in progress
- ram_done_o  output  1  one-cycle completion pulse
- ram_data_o  output  32  read word
- ram_err_o  output  1  out-of-range flag, valid with done

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; busy_o=0, done_o=0, err_o=0, data_o=0; wait counter=0.
  - The array contents are not cleared.
- All outputs are registered. busy_o is high exactly in BUSY; done_o is high exactly in DONE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If ce_i=1 at the edge, latch addr, we, data and sel; load counter=LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; the latched copies are used.
  - If counter≠0, decrement the counter.
  - If counter=0, perform the access at this edge and go to DONE.
- DONE:
  - done_o=1 for exactly one cycle; next edge goes to IDLE unconditionally.
  - ce_i in DONE is ignored. A request held high into the following IDLE cycle is accepted as a new request; loads are idempotent, so re-issue is harmless.
- Timing: request sampled at edge E. busy_o=1 for cycles E+1..E+LATENCY. done_o=1 in cycle E+LATENCY+1. Minimum request-to-request spacing is LATENCY+2 cycles.
- Indexing: word index = addr[ADDR_WIDTH+1:2]. In range iff addr[31:ADDR_WIDTH+2]==0.
- Write, in range:
  - For each n with sel[n]=1, mem[idx][8n+7:8n] ← data[8n+7:8n]; other lanes are unchanged.
  - sel=0000 completes normally with no change.
  - data_o is unchanged.
- Read, in range:
  - data_o ← mem[idx], the full word regardless of sel. It is held until the next read completes.
- Out of range:
  - No array write. A read loads data_o=0.
  - err_o=1 in the DONE cycle only; err_o=0 in every other cycle.
- Misaligned halfword or word: no special handling. The responder obeys sel and the word index; rejection belongs to the initiator.
- Reset mid-operation: the access is aborted and any pending write is never performed. Return to IDLE with outputs as at reset.
- Simultaneous rst and ce_i: reset wins and the request is dropped.

Test Plan:
1. Reset, LATENCY=2: rst high 2 cycles → busy=0, done=0, data_o=0. Then sw 0xDEADBEEF to addr 0x10 with sel=1111 → busy high 2 cycles, done in the 3rd cycle after capture, err=0.
2. Read-back: lw at 0x10 → done cycle data_o=0xDEADBEEF. Then sb 0xAA replicated (0xAAAAAAAA) at 0x11 with sel=0010, and lw 0x10 → 0xDEADAAEF.
3. Halfword lanes: sh 0x1234 replicated at 0x12 with sel=1100, then lw 0x10 → 0x1234AAEF. A write with sel=0000 → done pulses and the word is unchanged.
4. Out of range: read addr 0x00001000 (ADDR_WIDTH=10) → done with err=1 and data_o=0. A write there → err=1; reading addr 0x0 afterwards is unaffected.
5. Reset mid-write: sw 0xFFFFFFFF to 0x20, rst asserted in the 1st BUSY cycle → busy=0 the next cycle, no done. A later lw 0x20 returns the pre-existing value.
6. Back-to-back / held ce: ce held high continuously with lw 0x10 → done pulses every LATENCY+2 cycles. Inputs changed during BUSY do not alter the returned data. Repeat with LATENCY=1 and LATENCY=4 and confirm busy width equals LATENCY.
